// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the zero-latency instruction memory
// and captures the returned word into the IF/ID register. Illegal PCs halt fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, FAULT} state_t;

    // 33-bit limit so a depth of 2^30 words still compares correctly
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        vld_q, vld_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pc_illegal;

    assign pc_illegal = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        vld_d   = vld_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                end else if (flush_i) begin
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                    if (!stall_i) pc_d = pc_q + 32'd4;
                end else if (stall_i) begin
                    // everything holds
                end else if (pc_illegal) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                end else begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + 32'd4;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            FAULT: begin
                vld_d   = 1'b0;
                fault_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'd0;
            ipc4_q  <= 32'd0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            vld_q   <= vld_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ipc_q;
    assign if_id_pc_plus4 = ipc4_q;
    assign if_id_valid    = vld_q;
    assign fetch_fault    = fault_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// spec-level model; a second instance with a 4-word memory covers the range limit.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, redirect_valid;
    logic [31:0] redirect_pc, imem_rdata, imem_addr;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, fetch_fault;
    logic [31:0] s_rdata, s_addr, s_instr, s_pc, s_pc4, s_cnt;
    logic        s_valid, s_fault;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_vld, m_fault;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[11:2]];
    assign s_rdata    = mem[s_addr[11:2]];

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .stall_i(stall_i), .flush_i(flush_i), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    fetch_stage #(.IMEM_DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .imem_rdata(s_rdata), .imem_addr(s_addr),
        .stall_i(stall_i), .flush_i(flush_i), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_instr(s_instr), .if_id_pc(s_pc),
        .if_id_pc_plus4(s_pc4), .if_id_valid(s_valid),
        .fetch_fault(s_fault), .fetch_count(s_cnt)
    );

    function automatic bit legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc < 32'd4096);
    endfunction

    // Drive one cycle of inputs, advance the model by the spec rules, clock once.
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic rv, input logic [31:0] rpc);
        rst = r; stall_i = st; flush_i = fl; redirect_valid = rv; redirect_pc = rpc;
        if (!r) begin
            m_pc = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
            m_vld = 0; m_fault = 0; m_cnt = 0;
        end else if (m_fault) begin
            m_vld = 0;
        end else if (rv) begin
            m_pc = rpc; m_instr = NOP; m_vld = 0;
        end else if (fl) begin
            m_instr = NOP; m_vld = 0;
            if (!st) m_pc = m_pc + 4;
        end else if (!st) begin
            if (!legal(m_pc)) begin
                m_fault = 1; m_instr = NOP; m_vld = 0;
            end else begin
                m_instr = mem[m_pc[11:2]]; m_ipc = m_pc; m_ipc4 = m_pc + 4;
                m_vld = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h44);
        checks++;
        if (imem_addr !== 0 || if_id_instr !== NOP || if_id_pc !== 0 || if_id_pc_plus4 !== 0 ||
            if_id_valid !== 0 || fetch_fault !== 0 || fetch_count !== 0) begin
            errors++;
            $display("FAIL reset: addr=%h instr=%h pc=%h pc4=%h v=%b f=%b cnt=%0d",
                     imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
                     fetch_fault, fetch_count);
        end
    endtask

    task automatic test_first_fetch();
        mem[0] = 32'h00500093;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if (if_id_instr !== 32'h00500093 || if_id_pc !== 0 || if_id_pc_plus4 !== 4 ||
            if_id_valid !== 1 || imem_addr !== 4 || fetch_count !== 1) begin
            errors++;
            $display("FAIL first_fetch: instr=%h pc=%h pc4=%h v=%b addr=%h cnt=%0d want 00500093/0/4/1/4/1",
                     if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, imem_addr, fetch_count);
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        checks++;
        if (fetch_count !== 4 || imem_addr !== 32'h10 || if_id_pc !== 32'hC) begin
            errors++;
            $display("FAIL pre_stall: cnt=%0d addr=%h pc=%h want 4/10/c", fetch_count, imem_addr, if_id_pc);
        end
        repeat (2) begin
            step(1, 1, 0, 0, 0);
            checks++;
            if (imem_addr !== 32'h10 || if_id_pc !== 32'hC || if_id_instr !== mem[3] ||
                if_id_valid !== 1 || fetch_count !== 4) begin
                errors++;
                $display("FAIL stall_hold: addr=%h pc=%h instr=%h v=%b cnt=%0d",
                         imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
            end
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (fetch_count !== 5 || if_id_pc !== 32'h10 || if_id_instr !== mem[4] || imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL post_stall: cnt=%0d pc=%h instr=%h addr=%h want 5/10/%h/14",
                     fetch_count, if_id_pc, if_id_instr, imem_addr, mem[4]);
        end
    endtask

    task automatic test_redirect();
        step(1, 1, 1, 1, 32'h40);
        checks++;
        if (imem_addr !== 32'h40 || if_id_instr !== NOP || if_id_valid !== 0 || if_id_pc !== 32'h10) begin
            errors++;
            $display("FAIL redirect: addr=%h instr=%h v=%b pc=%h want 40/13/0/10",
                     imem_addr, if_id_instr, if_id_valid, if_id_pc);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (if_id_pc !== 32'h40 || if_id_valid !== 1 || if_id_instr !== mem[16] || if_id_pc_plus4 !== 32'h44) begin
            errors++;
            $display("FAIL redirect_fetch: pc=%h v=%b instr=%h pc4=%h", if_id_pc, if_id_valid,
                     if_id_instr, if_id_pc_plus4);
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        checks++;
        if (if_id_instr !== NOP || if_id_valid !== 0 || imem_addr !== 32'hC || fetch_count !== 2) begin
            errors++;
            $display("FAIL flush: instr=%h v=%b addr=%h cnt=%0d want 13/0/c/2",
                     if_id_instr, if_id_valid, imem_addr, fetch_count);
        end
        step(1, 1, 1, 0, 0);
        checks++;
        if (imem_addr !== 32'hC || if_id_valid !== 0) begin
            errors++;
            $display("FAIL flush_stall: addr=%h v=%b want c/0", imem_addr, if_id_valid);
        end
    endtask

    task automatic test_fault();
        step(1, 0, 0, 1, 32'h42);
        step(1, 0, 0, 0, 0);
        checks++;
        if (fetch_fault !== 1 || if_id_valid !== 0 || imem_addr !== 32'h42) begin
            errors++;
            $display("FAIL misalign: f=%b v=%b addr=%h want 1/0/42", fetch_fault, if_id_valid, imem_addr);
        end
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 1, 0, 0);
        checks++;
        if (fetch_fault !== 1 || imem_addr !== 32'h42 || if_id_valid !== 0 || fetch_count !== 2) begin
            errors++;
            $display("FAIL fault_sticky: f=%b addr=%h v=%b cnt=%0d want 1/42/0/2",
                     fetch_fault, imem_addr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_small_depth();
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            checks++;
            if (s_pc !== 32'(i * 4) || s_valid !== 1 || s_fault !== 0 || s_instr !== mem[i]) begin
                errors++;
                $display("FAIL small_fetch%0d: pc=%h v=%b f=%b instr=%h", i, s_pc, s_valid, s_fault, s_instr);
            end
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (s_fault !== 1 || s_valid !== 0 || s_addr !== 32'h10 || s_cnt !== 4) begin
            errors++;
            $display("FAIL small_range: f=%b v=%b addr=%h cnt=%0d want 1/0/10/4", s_fault, s_valid, s_addr, s_cnt);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (s_fault !== 0 || s_addr !== 0 || s_cnt !== 0) begin
            errors++;
            $display("FAIL small_reset: f=%b addr=%h cnt=%0d", s_fault, s_addr, s_cnt);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (s_valid !== 1 || s_cnt !== 1 || s_pc !== 0) begin
            errors++;
            $display("FAIL small_resume: v=%b cnt=%0d pc=%h", s_valid, s_cnt, s_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023)) << 2;
            step($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, rpc);
            checks++;
            if (imem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_ipc ||
                if_id_pc_plus4 !== m_ipc4 || if_id_valid !== m_vld || fetch_fault !== m_fault ||
                fetch_count !== m_cnt) begin
                errors++;
                $display("FAIL random%0d: addr=%h/%h instr=%h/%h pc=%h/%h pc4=%h/%h v=%b/%b f=%b/%b cnt=%0d/%0d",
                         i, imem_addr, m_pc, if_id_instr, m_instr, if_id_pc, m_ipc, if_id_pc_plus4, m_ipc4,
                         if_id_valid, m_vld, fetch_fault, m_fault, fetch_count, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 0; stall_i = 0; flush_i = 0; redirect_valid = 0; redirect_pc = 0;
        m_pc = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_vld = 0; m_fault = 0; m_cnt = 0;
        #2;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_flush();
        test_fault();
        test_small_depth();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
